mp_add_ctrl: RTL

MP_ADD_CTRL -- requirements
Module: mp_add_ctrl

---
 rtl/mp_add_ctrl_pkg.sv | 13 +
 rtl/mp_add_ctrl_bcla32.sv | 54 +++++
 rtl/mp_add_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/mp_add_ctrl_pkg.sv
// Shared definitions for the multi-precision adder controller and its word adder.
// Holds the machine-word width and the controller state encoding.
package mp_add_ctrl_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mp_add_ctrl_bcla32.sv
// 32-bit two-level carry-lookahead adder: 4-bit lookahead groups whose group
// generate/propagate terms feed a block-level carry chain.
module bcla32 (
  output logic        Cout,
  output logic [31:0] Sum,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin
);

  logic [31:0] p;
  logic [31:0] g;
  logic [31:0] c;
  logic [7:0]  grp_p;
  logic [7:0]  grp_g;
  logic [8:0]  blk_c;

  always_comb begin
    p     = A ^ B;
    g     = A & B;
    grp_p = '0;
    grp_g = '0;
    blk_c = '0;
    c     = '0;

    for (int j = 0; j < 8; j++) begin
      grp_p[j] = &p[4*j +: 4];
      grp_g[j] = g[4*j+3]
               | (p[4*j+3] & g[4*j+2])
               | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end

    blk_c[0] = Cin;
    for (int j = 0; j < 8; j++) begin
      blk_c[j+1] = grp_g[j] | (grp_p[j] & blk_c[j]);
    end

    // Bit carries inside each group are expanded from the group's carry-in.
    for (int j = 0; j < 8; j++) begin
      c[4*j]   = blk_c[j];
      c[4*j+1] = g[4*j] | (p[4*j] & blk_c[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])
               | (p[4*j+1] & p[4*j] & blk_c[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & blk_c[j]);
    end

    Sum  = p ^ c;
    Cout = blk_c[8];
  end

endmodule

// File: rtl/mp_add_ctrl.sv
// Word-serial N-bit add/subtract controller: one shared 32-bit CLA processes
// one word per cycle, least significant first, behind valid/ready handshakes.
module mp_add_ctrl
  import mp_add_ctrl_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORD_W*WORDS-1:0]   A,
  input  logic [WORD_W*WORDS-1:0]   B,
  input  logic                      sub,
  input  logic                      Cin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_W*WORDS-1:0]   Sum,
  output logic                      Cout,
  output logic                      Ovf
);

  localparam int N     = WORD_W * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t              state_q;
  state_t              state_d;
  logic [N-1:0]        a_q;
  logic [N-1:0]        b_q;
  logic                carry_q;
  logic [IDX_W-1:0]    idx_q;
  logic [WORD_W-1:0]   add_a;
  logic [WORD_W-1:0]   add_b;
  logic [WORD_W-1:0]   add_sum;
  logic                add_co;
  logic                last_word;

  assign add_a     = a_q[WORD_W*idx_q +: WORD_W];
  assign add_b     = b_q[WORD_W*idx_q +: WORD_W];
  assign last_word = (idx_q == LAST_IDX);

  bcla32 u_cla (
    .Cout (add_co),
    .Sum  (add_sum),
    .A    (add_a),
    .B    (add_b),
    .Cin  (carry_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_RUN;
      ST_RUN:  if (last_word) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  // Operand capture, word-serial accumulation and final flag update.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      Sum     <= '0;
      Cout    <= 1'b0;
      Ovf     <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= A;
            b_q     <= sub ? ~B : B;
            carry_q <= sub ? 1'b1 : Cin;
            idx_q   <= '0;
          end
        end
        ST_RUN: begin
          Sum[WORD_W*idx_q +: WORD_W] <= add_sum;
          carry_q <= add_co;
          if (last_word) begin
            idx_q <= '0;
            Cout  <= add_co;
            Ovf   <= (a_q[N-1] == b_q[N-1]) & (add_sum[WORD_W-1] != a_q[N-1]);
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
